// File: rtl/shift_accum_ram_v2.sv
// shift_accum_ram_v2: per-address read-modify-write accumulator on a
// dual-port RAM (port A read, port B write, 2-cycle read latency).
// Each request shifts SUMMAND_WIDTH bits into the word's LSBs (ACCUM),
// loads a zero-extended value (LOAD) or reads the word (READ / reserved).
// The two most recent S2 results are forwarded so same-address requests on
// consecutive cycles behave as if serialised. A clear request drains the
// pipeline, then sweeps zeros through every word, one word per cycle.
//
// Handshake: a request transfers on a rising clk_in edge where
// request_valid_in && ready_out; ready_out is high only in IDLE with
// clear_in low. Results are never back-pressured: result_valid_out is high
// for exactly one cycle per accepted request, two cycles after acceptance.
module shift_accum_ram_v2 #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 1024,
  parameter int SUMMAND_WIDTH = 1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     request_valid_in,
  input  logic [1:0]               op_in,
  input  logic [AW-1:0]            addr_in,
  input  logic [SUMMAND_WIDTH-1:0] summand_in,
  input  logic                     clear_in,
  output logic                     ready_out,
  output logic                     result_valid_out,
  output logic [AW-1:0]            addr_out,
  output logic [1:0]               op_out,
  output logic [WIDTH-1:0]         read_out,
  output logic [WIDTH-1:0]         sum_out,
  output logic                     overflow_out,
  output logic                     busy_out
);

  localparam int CW = AW + 1;
  localparam logic [1:0] OP_ACCUM = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t state_q, state_next;
  logic [CW-1:0] clr_cnt_q, clr_cnt_next;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q1, ram_q2;

  logic                     accept;
  logic                     s1_valid, s2_valid;
  logic [1:0]               s1_op, s2_op;
  logic [AW-1:0]            s1_addr, s2_addr;
  logic [SUMMAND_WIDTH-1:0] s1_summand, s2_summand;

  logic             h1_wrote, h2_wrote;
  logic [AW-1:0]    h1_addr, h2_addr;
  logic [WIDTH-1:0] h1_sum, h2_sum;

  logic [WIDTH-1:0] old_word, new_word;
  logic             ovf;
  logic             s2_we;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign ready_out = (state_q == IDLE) && !clear_in;
  assign busy_out  = (state_q != IDLE);
  assign accept    = request_valid_in && ready_out;

  // RAM port A: address registered in S0, internal register in S1, data in S2.
  always_ff @(posedge clk_in) begin
    ram_q1 <= mem[addr_in];
    ram_q2 <= ram_q1;
  end

  // RAM port B: single write port shared by the clear sweep and S2 commits.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Pipeline stage registers; only the valids need reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
    s1_op      <= op_in;
    s1_addr    <= addr_in;
    s1_summand <= summand_in;
    s2_op      <= s1_op;
    s2_addr    <= s1_addr;
    s2_summand <= s1_summand;
  end

  // Forwarding history: H1 is last cycle's S2 result, H2 the one before.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || state_q == CLEAR) begin
      h1_wrote <= 1'b0;
      h2_wrote <= 1'b0;
    end else begin
      h1_wrote <= s2_we;
      h2_wrote <= h1_wrote;
    end
    h1_addr <= s2_addr;
    h1_sum  <= new_word;
    h2_addr <= h1_addr;
    h2_sum  <= h1_sum;
  end

  // S2: pick the freshest copy of the word, then compute the new value.
  always_comb begin
    old_word = ram_q2;
    if (h1_wrote && h1_addr == s2_addr)      old_word = h1_sum;
    else if (h2_wrote && h2_addr == s2_addr) old_word = h2_sum;
    new_word = old_word;
    ovf      = 1'b0;
    case (s2_op)
      OP_ACCUM: begin
        new_word = {old_word[WIDTH-SUMMAND_WIDTH-1:0], s2_summand};
        ovf      = |old_word[WIDTH-1 -: SUMMAND_WIDTH];
      end
      OP_LOAD:  new_word = WIDTH'(s2_summand);
      default:  ;
    endcase
  end

  assign s2_we = s2_valid && (s2_op == OP_ACCUM || s2_op == OP_LOAD);

  // Port B source select: the sweep only runs while the pipeline is empty.
  always_comb begin
    wr_en   = s2_we;
    wr_addr = s2_addr;
    wr_data = new_word;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q[AW-1:0];
      wr_data = '0;
    end
  end

  assign result_valid_out = s2_valid;
  assign addr_out         = s2_valid ? s2_addr  : '0;
  assign op_out           = s2_valid ? s2_op    : '0;
  assign read_out         = s2_valid ? old_word : '0;
  assign sum_out          = s2_valid ? new_word : '0;
  assign overflow_out     = s2_valid ? ovf      : 1'b0;

  // Control FSM state register; reset enters the sweep so memory starts zeroed.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_next;
      clr_cnt_q <= clr_cnt_next;
    end
  end

  // Control FSM next state: IDLE -> DRAIN on clear_in, DRAIN -> CLEAR once
  // S1/S2 are empty, CLEAR -> IDLE after the last word.
  always_comb begin
    state_next   = state_q;
    clr_cnt_next = clr_cnt_q;
    case (state_q)
      IDLE:  if (clear_in) state_next = DRAIN;
      DRAIN: begin
        if (!s1_valid && !s2_valid) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CW'(DEPTH - 1)) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_q + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_accum_ram_v2.sv
// Bench for shift_accum_ram_v2: two instances (SUMMAND_WIDTH 1 and 2,
// WIDTH 8, DEPTH 16). Drivers push hand-computed expected results into
// per-instance queues; negedge monitors pop and compare on result_valid_out.
module tb_shift_accum_ram_v2;

  localparam int EW = 23;  // {addr[3:0], op[1:0], read[7:0], sum[7:0], ovf}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SUMMAND_WIDTH = 1
  logic       a_valid, a_summand, a_clear;
  logic [1:0] a_op;
  logic [3:0] a_addr;
  logic       a_ready, a_rv, a_ovf, a_busy;
  logic [3:0] a_addr_o;
  logic [1:0] a_op_o;
  logic [7:0] a_read, a_sum;

  // Instance B: SUMMAND_WIDTH = 2
  logic       b_valid, b_clear;
  logic [1:0] b_op, b_summand;
  logic [3:0] b_addr;
  logic       b_ready, b_rv, b_ovf, b_busy;
  logic [3:0] b_addr_o;
  logic [1:0] b_op_o;
  logic [7:0] b_read, b_sum;

  shift_accum_ram_v2 #(.WIDTH(8), .DEPTH(16), .SUMMAND_WIDTH(1)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .request_valid_in(a_valid), .op_in(a_op),
    .addr_in(a_addr), .summand_in(a_summand), .clear_in(a_clear),
    .ready_out(a_ready), .result_valid_out(a_rv), .addr_out(a_addr_o),
    .op_out(a_op_o), .read_out(a_read), .sum_out(a_sum),
    .overflow_out(a_ovf), .busy_out(a_busy)
  );

  shift_accum_ram_v2 #(.WIDTH(8), .DEPTH(16), .SUMMAND_WIDTH(2)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .request_valid_in(b_valid), .op_in(b_op),
    .addr_in(b_addr), .summand_in(b_summand), .clear_in(b_clear),
    .ready_out(b_ready), .result_valid_out(b_rv), .addr_out(b_addr_o),
    .op_out(b_op_o), .read_out(b_read), .sum_out(b_sum),
    .overflow_out(b_ovf), .busy_out(b_busy)
  );

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [3:0] a, input logic [1:0] o,
                                         input logic [7:0] r, input logic [7:0] s,
                                         input logic v);
    return {a, o, r, s, v};
  endfunction

  // Monitor A: compare every presented result; outputs must be 0 otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rv) begin
        if (exp_a_q.size() == 0) check("a_unexpected_result", 32'd1, 32'd0);
        else check("a_result(addr,op,read,sum,ovf)",
                   32'(pack(a_addr_o, a_op_o, a_read, a_sum, a_ovf)),
                   32'(exp_a_q.pop_front()));
      end else begin
        check("a_idle_outputs_zero", 32'(pack(a_addr_o, a_op_o, a_read, a_sum, a_ovf)), 32'd0);
      end
    end
  end

  // Monitor B: compare every presented result.
  always @(negedge clk) begin
    if (rst_n && b_rv) begin
      if (exp_b_q.size() == 0) check("b_unexpected_result", 32'd1, 32'd0);
      else check("b_result(addr,op,read,sum,ovf)",
                 32'(pack(b_addr_o, b_op_o, b_read, b_sum, b_ovf)),
                 32'(exp_b_q.pop_front()));
    end
  end

  task automatic send_a(input logic [1:0] op, input logic [3:0] addr, input logic sm,
                        input logic [7:0] er, input logic [7:0] es, input logic eo);
    a_valid = 1'b1; a_op = op; a_addr = addr; a_summand = sm;
    #1;
    check("a_ready", 32'(a_ready), 32'd1);
    if (a_ready) exp_a_q.push_back(pack(addr, op, er, es, eo));
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] op, input logic [3:0] addr, input logic [1:0] sm,
                        input logic [7:0] er, input logic [7:0] es, input logic eo);
    b_valid = 1'b1; b_op = op; b_addr = addr; b_summand = sm;
    #1;
    check("b_ready", 32'(b_ready), 32'd1);
    if (b_ready) exp_b_q.push_back(pack(addr, op, er, es, eo));
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Counts negedges with ready_out low, bounded; leaves time at posedge+1.
  task automatic count_ready_low(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_ready) break;
      cnt++;
    end
    @(posedge clk); #1;
  endtask

  int cnt;
  int bits[8]        = '{1, 0, 1, 1, 0, 0, 1, 0};
  logic [7:0] sums[8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
  logic [7:0] prev;

  initial begin
    a_valid = 0; a_op = 0; a_addr = 0; a_summand = 0; a_clear = 0;
    b_valid = 0; b_op = 0; b_addr = 0; b_summand = 0; b_clear = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(a_ready), 32'd0);
    check("reset_busy", 32'(a_busy), 32'd1);
    check("reset_result_valid", 32'(a_rv), 32'd0);
    check("reset_outputs_zero", 32'(pack(a_addr_o, a_op_o, a_read, a_sum, a_ovf)), 32'd0);
    check("reset_b_ready", 32'(b_ready), 32'd0);

    // Post-reset sweep: ready low for exactly DEPTH cycles
    rst_n = 1'b1;
    count_ready_low(cnt);
    check("post_reset_ready_low_cycles", 32'(cnt), 32'd16);
    check("post_reset_busy", 32'(a_busy), 32'd0);
    for (int i = 0; i < 16; i++) send_a(2'd2, 4'(i), 1'b0, 8'h00, 8'h00, 1'b0);

    // Serial ACCUM to addr 3, back-to-back
    prev = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_a(2'd0, 4'd3, 1'(bits[i]), prev, sums[i], 1'b0);
      prev = sums[i];
    end
    // Reserved opcode reads without writing
    send_a(2'd3, 4'd3, 1'b1, 8'hB2, 8'hB2, 1'b0);
    send_a(2'd2, 4'd3, 1'b0, 8'hB2, 8'hB2, 1'b0);

    // Forwarding mix: alternating addresses (H2 path)
    send_a(2'd1, 4'd5, 1'b1, 8'h00, 8'h01, 1'b0);
    send_a(2'd1, 4'd6, 1'b1, 8'h00, 8'h01, 1'b0);
    send_a(2'd0, 4'd5, 1'b1, 8'h01, 8'h03, 1'b0);
    send_a(2'd0, 4'd6, 1'b1, 8'h01, 8'h03, 1'b0);
    // Consecutive same address (H1 path)
    send_a(2'd1, 4'd9, 1'b1, 8'h00, 8'h01, 1'b0);
    send_a(2'd0, 4'd9, 1'b1, 8'h01, 8'h03, 1'b0);
    // Gap of 1 cycle
    send_a(2'd1, 4'd10, 1'b1, 8'h00, 8'h01, 1'b0);
    idle(1);
    send_a(2'd0, 4'd10, 1'b1, 8'h01, 8'h03, 1'b0);
    // Gap of 2 cycles (RAM path)
    send_a(2'd1, 4'd11, 1'b1, 8'h00, 8'h01, 1'b0);
    idle(2);
    send_a(2'd0, 4'd11, 1'b1, 8'h01, 8'h03, 1'b0);
    // H1 beats H2 when both match
    send_a(2'd1, 4'd12, 1'b1, 8'h00, 8'h01, 1'b0);
    send_a(2'd0, 4'd12, 1'b1, 8'h01, 8'h03, 1'b0);
    send_a(2'd0, 4'd12, 1'b0, 8'h03, 8'h06, 1'b0);
    idle(3);
    send_a(2'd2, 4'd5, 1'b0, 8'h03, 8'h03, 1'b0);
    send_a(2'd2, 4'd6, 1'b0, 8'h03, 8'h03, 1'b0);
    send_a(2'd2, 4'd9, 1'b0, 8'h03, 8'h03, 1'b0);
    send_a(2'd2, 4'd10, 1'b0, 8'h03, 8'h03, 1'b0);
    send_a(2'd2, 4'd11, 1'b0, 8'h03, 8'h03, 1'b0);
    send_a(2'd2, 4'd12, 1'b0, 8'h06, 8'h06, 1'b0);

    // Overflow on the 2-bit instance
    send_b(2'd1, 4'd2, 2'b00, 8'h00, 8'h00, 1'b0);
    send_b(2'd0, 4'd2, 2'b11, 8'h00, 8'h03, 1'b0);
    send_b(2'd0, 4'd2, 2'b11, 8'h03, 8'h0F, 1'b0);
    send_b(2'd0, 4'd2, 2'b11, 8'h0F, 8'h3F, 1'b0);
    send_b(2'd0, 4'd2, 2'b11, 8'h3F, 8'hFF, 1'b0);
    send_b(2'd0, 4'd2, 2'b00, 8'hFF, 8'hFC, 1'b1);

    // Clear handshake during traffic
    send_a(2'd0, 4'd3, 1'b1, 8'hB2, 8'h65, 1'b1);
    send_a(2'd0, 4'd7, 1'b1, 8'h00, 8'h01, 1'b0);
    a_clear = 1'b1; a_valid = 1'b1; a_op = 2'd0; a_addr = 4'd4; a_summand = 1'b1;
    #1;
    check("ready_low_with_clear", 32'(a_ready), 32'd0);
    check("busy_low_before_clear", 32'(a_busy), 32'd0);
    @(posedge clk); #1;
    a_clear = 1'b0; a_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!a_busy) break;
      cnt++;
    end
    check("clear_busy_cycles", 32'(cnt), 32'd18);
    @(posedge clk); #1;
    send_a(2'd2, 4'd3, 1'b0, 8'h00, 8'h00, 1'b0);
    send_a(2'd2, 4'd4, 1'b0, 8'h00, 8'h00, 1'b0);
    send_a(2'd2, 4'd7, 1'b0, 8'h00, 8'h00, 1'b0);
    send_a(2'd2, 4'd12, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset mid-sweep at c = 7
    send_a(2'd1, 4'd1, 1'b1, 8'h00, 8'h01, 1'b0);
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(7);
    rst_n = 1'b0;
    #1;
    check("mid_sweep_busy", 32'(a_busy), 32'd1);
    idle(2);
    rst_n = 1'b1;
    count_ready_low(cnt);
    check("mid_sweep_restart_ready_low_cycles", 32'(cnt), 32'd16);
    send_a(2'd2, 4'd1, 1'b0, 8'h00, 8'h00, 1'b0);
    send_a(2'd2, 4'd15, 1'b0, 8'h00, 8'h00, 1'b0);

    // Drain scoreboards (bounded)
    for (int i = 0; i < 20; i++) begin
      if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
